tlv5618_rx: RTL

- Receiver end of the TLV5618 3-wire serial link (cs_n/din/sclk) driven by the DAC transmitter.
- Oversamples the link in the system clock domain, shifts in 16-bit MSB-first frames on SCLK falling edges and decodes the TLV5618 control nibble.
- Maintains DAC A, DAC B and double-buffer registers exactly as the device does.
- Used as a synthesizable DAC model and loopback checker in FPGA test designs.

---
 rtl/tlv5618_rx.sv | 91 +++++++++
 1 files changed

// File: rtl/tlv5618_rx.sv
// tlv5618_rx: oversampling receiver for the TLV5618 3-wire DAC link with device register model.
module tlv5618_rx #(
   parameter int SyncStages = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dac_cs_n,
   input  logic        dac_din,
   input  logic        dac_sclk,
   output logic        word_valid,
   output logic [15:0] word,
   output logic        frame_err,
   output logic        rsvd_err,
   output logic [11:0] dac_a,
   output logic [11:0] dac_b,
   output logic [11:0] buffer,
   output logic        spd,
   output logic        pwr
);
   typedef enum logic {IDLE, ARMED} state_t;
   state_t state, state_nxt;
   logic [SyncStages-1:0] cs_sync, sclk_sync, din_sync;
   logic s_cs, s_sclk, s_din, s_cs_d, s_sclk_d;
   logic cs_fall, cs_rise, sclk_fall, capture, close, good, rsvd, upd;
   logic [15:0] shreg, sh_nxt;
   logic [4:0] bit_cnt, cnt_nxt;
   logic [1:0] r;
   assign s_cs   = cs_sync[SyncStages-1];
   assign s_sclk = sclk_sync[SyncStages-1];
   assign s_din  = din_sync[SyncStages-1];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         din_sync  <= '0;
         s_cs_d    <= 1'b1;
         s_sclk_d  <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SyncStages-2:0], dac_cs_n};
         sclk_sync <= {sclk_sync[SyncStages-2:0], dac_sclk};
         din_sync  <= {din_sync[SyncStages-2:0], dac_din};
         s_cs_d    <= s_cs;
         s_sclk_d  <= s_sclk;
      end
   assign cs_fall   = s_cs_d & ~s_cs;
   assign cs_rise   = ~s_cs_d & s_cs;
   assign sclk_fall = s_sclk_d & ~s_sclk;
   // A falling SCLK coinciding with the closing CS edge still belongs to the frame.
   assign capture = sclk_fall && state == ARMED && (!s_cs || cs_rise);
   assign sh_nxt  = capture ? {shreg[14:0], s_din} : shreg;
   assign cnt_nxt = capture ? (bit_cnt == 5'd17 ? bit_cnt : bit_cnt + 5'd1) : bit_cnt;
   assign close   = cs_rise && state == ARMED;
   assign good    = close && cnt_nxt == 5'd16;
   assign r       = {sh_nxt[15], sh_nxt[12]};
   assign rsvd    = r == 2'b11;
   assign upd     = good & ~rsvd;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      if (cs_fall) state_nxt = ARMED;
      else if (close) state_nxt = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         word_valid <= 1'b0;
         word       <= '0;
         frame_err  <= 1'b0;
         rsvd_err   <= 1'b0;
         dac_a      <= '0;
         dac_b      <= '0;
         buffer     <= '0;
         spd        <= 1'b0;
         pwr        <= 1'b0;
      end else begin
         shreg      <= sh_nxt;
         bit_cnt    <= cs_fall ? 5'd0 : cnt_nxt;
         word_valid <= good;
         frame_err  <= close && cnt_nxt != 5'd16;
         rsvd_err   <= good && rsvd;
         word       <= good ? sh_nxt : word;
         dac_a      <= (upd && r == 2'b10) ? sh_nxt[11:0] : dac_a;
         dac_b      <= (upd && r == 2'b00) ? sh_nxt[11:0] : (upd && r == 2'b10) ? buffer : dac_b;
         buffer     <= (upd && !r[1]) ? sh_nxt[11:0] : buffer;
         spd        <= upd ? sh_nxt[14] : spd;
         pwr        <= upd ? sh_nxt[13] : pwr;
      end
endmodule
